// File: rtl/seq_detect_pkg.sv
// Shared types, parameter limits and helpers for the serial sequence detector.
// The hit counter is only built when SEQ_DETECT_HIT_COUNT_EN is defined.
package seq_detect_pkg;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;
   localparam int CNT_W_MIN   = 1;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_SAMPLE,
      OP_LOAD
   } op_e;

   function automatic int state_w(input int len);
      return $clog2(len + 1);
   endfunction

   function automatic bit pat_len_ok(input int len);
      return (len >= PAT_LEN_MIN) && (len <= PAT_LEN_MAX);
   endfunction

endpackage

// File: rtl/seq_detect_match.sv
// Combinational prefix/suffix search: longest pattern prefix (up to bound)
// that equals the newest bits of the sampled history including the current bit.
module seq_detect_match
   import seq_detect_pkg::*;
#(
   parameter  int PAT_LEN = 4,
   localparam int SW      = state_w(PAT_LEN)
) (
   input  logic [PAT_LEN-1:0] pat,
   input  logic [PAT_LEN-1:0] hist_x,
   input  logic [SW-1:0]      bound,
   output logic [SW-1:0]      next_s
);

   // k_ok[gi] means a match of length gi+1 is both allowed and present
   logic [PAT_LEN-1:0] k_ok;

   generate
      for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_len
         assign k_ok[gi] = (pat[PAT_LEN-1 -: gi+1] == hist_x[gi:0]) &&
                           (SW'(gi + 1) <= bound);
      end
   endgenerate

   always_comb begin
      next_s = '0;
      for (int k = 0; k < PAT_LEN; k++) begin
         if (k_ok[k]) next_s = SW'(k + 1);
      end
   end

endmodule

// File: rtl/seq_detect_fsm.sv
// Parametrised Moore serial-sequence detector with programmable pattern.
// Define SEQ_DETECT_HIT_COUNT_EN to build the saturating hit counter.
module seq_detect_fsm
   import seq_detect_pkg::*;
#(
   parameter  int                 PAT_LEN = 4,
   parameter  logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter  bit                 OVERLAP = 1'b1,
   parameter  int                 CNT_W   = 8,
   localparam int                 SW      = state_w(PAT_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               x,
   input  logic               load,
   input  logic [PAT_LEN-1:0] load_pat,
   output logic               y,
   output logic [SW-1:0]      currentState,
   output logic [CNT_W-1:0]   hit_count
);

   generate
      if (!pat_len_ok(PAT_LEN)) begin : g_bad_len
         $error("seq_detect_fsm: PAT_LEN out of range 2..16");
      end
      if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
         $error("seq_detect_fsm: CNT_W must be at least 1");
      end
   endgenerate

   op_e                op;
   logic [PAT_LEN-1:0] pat_reg,   pat_next;
   // The oldest history bit is shifted out before it could join a match
   logic [PAT_LEN-2:0] hist_reg,  hist_next;
   logic [SW-1:0]      state_reg, state_next;
   logic [SW-1:0]      bound;
   logic [SW-1:0]      match_s;
   logic [PAT_LEN-1:0] hist_x;

   assign hist_x = {hist_reg, x};

   always_comb begin
      op = OP_HOLD;
      if (load)    op = OP_LOAD;
      else if (en) op = OP_SAMPLE;
   end

   // A completed match restarts from scratch unless overlaps are allowed
   always_comb begin
      bound = state_reg + SW'(1);
      if (state_reg == SW'(PAT_LEN)) bound = OVERLAP ? SW'(PAT_LEN) : SW'(1);
   end

   seq_detect_match #(
      .PAT_LEN (PAT_LEN)
   ) u_match (
      .pat    (pat_reg),
      .hist_x (hist_x),
      .bound  (bound),
      .next_s (match_s)
   );

   always_comb begin
      pat_next   = pat_reg;
      hist_next  = hist_reg;
      state_next = state_reg;
      case (op)
         OP_LOAD: begin
            pat_next   = load_pat;
            hist_next  = '0;
            state_next = '0;
         end
         OP_SAMPLE: begin
            hist_next  = hist_x[PAT_LEN-2:0];
            state_next = match_s;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_reg   <= PATTERN;
         hist_reg  <= '0;
         state_reg <= '0;
      end else begin
         pat_reg   <= pat_next;
         hist_reg  <= hist_next;
         state_reg <= state_next;
      end
   end

   assign y            = (state_reg == SW'(PAT_LEN));
   assign currentState = state_reg;

`ifdef SEQ_DETECT_HIT_COUNT_EN
   logic             hit;
   logic [CNT_W-1:0] cnt_reg;

   assign hit = (op == OP_SAMPLE) && (match_s == SW'(PAT_LEN));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (op == OP_LOAD) begin
         cnt_reg <= '0;
      end else if (hit && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign hit_count = cnt_reg;
`else
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three instances (overlap, non-overlap, 2-bit counter)
// driven by one stimulus and checked against a window-search reference model.
module tb_seq_detect_fsm;

   logic       clk = 1'b0;
   logic       reset, en, x, load;
   logic [3:0] load_pat;

   logic       y_a, y_b, y_c;
   logic [2:0] s_a, s_b, s_c;
   logic [7:0] hc_a, hc_b;
   logic [1:0] hc_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .load_pat(load_pat),
      .y(y_a), .currentState(s_a), .hit_count(hc_a));
   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .load_pat(load_pat),
      .y(y_b), .currentState(s_b), .hit_count(hc_b));
   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .load_pat(load_pat),
      .y(y_c), .currentState(s_c), .hit_count(hc_c));

   // Reference: window of received bits since the last clear (or last
   // non-overlapping hit); state is the longest pattern prefix ending it.
   int          m_ov   [3] = '{1, 0, 1};
   int          m_cmax [3] = '{255, 255, 3};
   logic [63:0] m_w    [3];
   int          m_n    [3];
   int          m_s    [3];
   int          m_c    [3];
   logic [3:0]  m_pat;

   function automatic int calc_s(input logic [63:0] w, input int n, input logic [3:0] p);
      int best = 0;
      for (int k = 1; k <= 4; k++) begin
         bit ok = (k <= n);
         for (int j = 0; j < k; j++) if (w[j] != p[4-k+j]) ok = 0;
         if (ok) best = k;
      end
      return best;
   endfunction

   function automatic logic [31:0] exp_hc(input int i);
`ifdef SEQ_DETECT_HIT_COUNT_EN
      return m_c[i];
`else
      return (i < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic model_clear(input logic [3:0] p);
      m_pat = p;
      for (int i = 0; i < 3; i++) begin
         m_w[i] = '0; m_n[i] = 0; m_s[i] = 0; m_c[i] = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a.y", 32'(y_a), 32'(m_s[0] == 4));
      chk("a.s", 32'(s_a), 32'(m_s[0]));
      chk("a.hc", 32'(hc_a), exp_hc(0));
      chk("b.y", 32'(y_b), 32'(m_s[1] == 4));
      chk("b.s", 32'(s_b), 32'(m_s[1]));
      chk("b.hc", 32'(hc_b), exp_hc(1));
      chk("c.y", 32'(y_c), 32'(m_s[2] == 4));
      chk("c.s", 32'(s_c), 32'(m_s[2]));
      chk("c.hc", 32'(hc_c), exp_hc(2));
   endtask

   task automatic step(input logic r, input logic l, input logic e, input logic xi,
                       input logic [3:0] lp);
      reset = r; load = l; en = e; x = xi; load_pat = lp;
      @(posedge clk);
      if (r) begin
         model_clear(4'b1011);
      end else if (l) begin
         model_clear(lp);
      end else if (e) begin
         for (int i = 0; i < 3; i++) begin
            m_w[i] = {m_w[i][62:0], xi};
            m_n[i] = (m_n[i] < 64) ? m_n[i] + 1 : 64;
            m_s[i] = calc_s(m_w[i], m_n[i], m_pat);
            if (m_s[i] == 4) begin
               if (m_c[i] < m_cmax[i]) m_c[i]++;
               if (m_ov[i] == 0) m_n[i] = 0;
            end
         end
      end
      #1;
      check_all();
      $display("step r=%0b l=%0b en=%0b x=%0b lp=%b | S a/b/c=%0d/%0d/%0d hc=%0d/%0d/%0d",
               r, l, e, xi, lp, s_a, s_b, s_c, hc_a, hc_b, hc_c);
   endtask

   task automatic sample(input logic xi);
      step(1'b0, 1'b0, 1'b1, xi, 4'b0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic st    [7] = '{1, 0, 1, 1, 0, 1, 1};
      int   exp_a [7] = '{1, 2, 3, 4, 2, 3, 4};
      int   exp_b [7] = '{1, 2, 3, 4, 0, 1, 1};
      int   exp_c6[5] = '{1, 2, 3, 3, 3};
      logic p1011 [4] = '{1, 0, 1, 1};
      logic p0110 [4] = '{0, 1, 1, 0};

      reset = 1'b1; en = 1'b1; x = 1'b1; load = 1'b0; load_pat = 4'b0000;
      model_clear(4'b1011);

      // Reset held with activity on the inputs
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
      chk("t1.s", 32'(s_a), 32'd0);
      chk("t1.y", 32'(y_a), 32'd0);

      // Overlapping vs restarting detection on the same stream
      for (int i = 0; i < 7; i++) begin
         sample(st[i]);
         chk("t2.a.s", 32'(s_a), 32'(exp_a[i]));
         chk("t3.b.s", 32'(s_b), 32'(exp_b[i]));
      end
`ifdef SEQ_DETECT_HIT_COUNT_EN
      chk("t2.a.hc", 32'(hc_a), 32'd2);
      chk("t3.b.hc", 32'(hc_b), 32'd1);
`endif

      // Hold while en is low
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      sample(1'b1); sample(1'b0); sample(1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'(i % 2), 4'b0000);
      chk("t4.hold", 32'(s_a), 32'd3);
      sample(1'b1);
      chk("t4.s", 32'(s_a), 32'd4);

      // Load with a simultaneous sample, then match the new pattern
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      sample(1'b1); sample(1'b0); sample(1'b1);
      chk("t5.pre", 32'(s_a), 32'd3);
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
      chk("t5.load", 32'(s_a), 32'd0);
      for (int i = 0; i < 4; i++) sample(p0110[i]);
      chk("t5.s", 32'(s_a), 32'd4);

      // Counter saturation, then reset mid-pattern
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      for (int g = 0; g < 5; g++) begin
         for (int i = 0; i < 4; i++) sample(p1011[i]);
`ifdef SEQ_DETECT_HIT_COUNT_EN
         chk("t6.c.hc", 32'(hc_c), 32'(exp_c6[g]));
`endif
      end
      sample(1'b1); sample(1'b0);
      chk("t6.mid", 32'(s_c), 32'd2);
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
      chk("t6.rst", 32'(s_c), 32'd0);

      // All-ones pattern: every continuing 1 is a hit when overlapping
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
      for (int i = 0; i < 6; i++) sample(1'b1);
`ifdef SEQ_DETECT_HIT_COUNT_EN
      chk("ones.a.hc", 32'(hc_a), 32'd3);
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic r, l, e, xi;
         logic [3:0] lp;
         r  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 3);
         e  = ($urandom_range(0, 99) < 75);
         xi = 1'($urandom_range(0, 1));
         lp = 4'($urandom_range(0, 15));
         step(r, l, e, xi, lp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
